// File: rtl/mlvds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mlvds_pkg                                                            |
// | Shared state encodings and timing defaults for the MLVDS tx path.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mlvds_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_arb   = 3'd1;
    localparam state_t c_st_pre   = 3'd2;
    localparam state_t c_st_start = 3'd3;
    localparam state_t c_st_busy  = 3'd4;
    localparam state_t c_st_post  = 3'd5;
    localparam state_t c_st_hold  = 3'd6;

    localparam int          c_quiet_default      = 32;
    localparam int          c_guard_default      = 4;
    localparam int          c_turnaround_default = 16;
    localparam logic [15:0] c_tx_timeout_default = 16'hffff;

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb                                                               |
// | N-bit round-robin one-hot picker with its own pointer register.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_update,
    input  logic [N-1:0] i_last,
    output logic [N-1:0] o_pick
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_nxt;

    // Walk from the farthest candidate down so the one nearest the pointer wins.
    always_comb begin
        int            s;
        logic [PW-1:0] idx;
        s      = 0;
        idx    = '0;
        o_pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = k + int'(r_ptr);
            if (s >= N) s = s - N;
            idx = s[PW-1:0];
            if (i_req[idx]) begin
                o_pick      = '0;
                o_pick[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int j = 0; j < N; j++) begin
            if (i_last[j]) w_ptr_nxt = (j == N - 1) ? '0 : PW'(j + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_ptr <= '0;
        else if (i_update) r_ptr <= w_ptr_nxt;
    end

endmodule
`default_nettype wire

// File: rtl/mlvds_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mlvds_tx_sched                                                       |
// | Arbitrates the half-duplex MLVDS transceiver among N tx requesters.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mlvds_tx_sched
    import mlvds_pkg::*;
#(
    parameter int          N          = 2,
    parameter int          QUIET      = c_quiet_default,
    parameter int          GUARD_PRE  = c_guard_default,
    parameter int          GUARD_POST = c_guard_default,
    parameter int          TURNAROUND = c_turnaround_default,
    parameter logic [15:0] TX_TIMEOUT = c_tx_timeout_default
) (
    input  logic         c,
    input  logic         rst,
    input  logic         rx_active,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [N-1:0] done,
    output logic         err,
    output logic         tx_start,
    input  logic         tx_busy,
    output logic         de,
    output logic         tx_active
);

    localparam logic [15:0] c_quiet     = 16'(QUIET);
    localparam logic [7:0]  c_gpre_last = 8'(GUARD_PRE - 1);
    localparam logic [7:0]  c_gpst_last = 8'(GUARD_POST - 1);
    localparam logic [7:0]  c_turn_last = 8'(TURNAROUND - 1);

    state_t         r_state, w_nstate;
    logic [15:0]    r_qcnt, w_qcnt;
    logic [15:0]    r_tcnt, w_tcnt;
    logic [7:0]     r_gcnt, w_gcnt;
    logic           r_seen, w_seen;
    logic           r_errf, w_errf;
    logic [N-1:0]   w_grant;
    logic [N-1:0]   w_pick;
    logic           w_upd;
    logic           w_done;
    logic           w_de;

    rr_arb #(.N(N)) u_arb (
        .clk      (c),
        .rst      (rst),
        .i_req    (req),
        .i_update (w_upd),
        .i_last   (grant),
        .o_pick   (w_pick)
    );

    // Next-state and next-counter values; outputs are registered from these so
    // each output is valid in the same cycle as the state it belongs to.
    always_comb begin
        w_nstate = r_state;
        w_qcnt   = r_qcnt;
        w_tcnt   = r_tcnt;
        w_gcnt   = r_gcnt;
        w_seen   = r_seen;
        w_errf   = r_errf;
        w_grant  = grant;
        w_upd    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (rx_active)             w_qcnt = '0;
                else if (r_qcnt != c_quiet) w_qcnt = r_qcnt + 16'd1;
                if ((r_qcnt == c_quiet) && (|req)) w_nstate = c_st_arb;
            end
            c_st_arb: begin
                if (|req) begin
                    w_grant  = w_pick;
                    w_gcnt   = '0;
                    w_errf   = 1'b0;
                    w_nstate = c_st_pre;
                end else begin
                    w_nstate = c_st_idle;
                end
            end
            c_st_pre: begin
                if (!(|(req & grant))) begin
                    w_errf   = 1'b1;
                    w_gcnt   = '0;
                    w_nstate = c_st_post;
                end else if (r_gcnt == c_gpre_last) begin
                    w_tcnt   = '0;
                    w_seen   = 1'b0;
                    w_nstate = c_st_start;
                end else begin
                    w_gcnt = r_gcnt + 8'd1;
                end
            end
            c_st_start: begin
                w_tcnt   = r_tcnt + 16'd1;
                w_nstate = c_st_busy;
            end
            c_st_busy: begin
                if (tx_busy) w_seen = 1'b1;
                if (r_seen && !tx_busy) begin
                    w_gcnt   = '0;
                    w_nstate = c_st_post;
                end else if (r_tcnt == TX_TIMEOUT) begin
                    w_errf   = 1'b1;
                    w_gcnt   = '0;
                    w_nstate = c_st_post;
                end else begin
                    w_tcnt = r_tcnt + 16'd1;
                end
            end
            c_st_post: begin
                if (r_gcnt == c_gpst_last) begin
                    w_upd    = 1'b1;
                    w_grant  = '0;
                    w_gcnt   = '0;
                    w_nstate = c_st_hold;
                end else begin
                    w_gcnt = r_gcnt + 8'd1;
                end
            end
            c_st_hold: begin
                if (r_gcnt == c_turn_last) begin
                    w_qcnt   = '0;
                    w_nstate = c_st_idle;
                end else begin
                    w_gcnt = r_gcnt + 8'd1;
                end
            end
            default: w_nstate = c_st_idle;
        endcase
        w_done = (w_nstate == c_st_post) && (w_gcnt == c_gpst_last);
        w_de   = (w_nstate == c_st_pre) || (w_nstate == c_st_start) ||
                 (w_nstate == c_st_busy) || (w_nstate == c_st_post);
    end

    always_ff @(posedge c) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_qcnt    <= '0;
            r_tcnt    <= '0;
            r_gcnt    <= '0;
            r_seen    <= 1'b0;
            r_errf    <= 1'b0;
            grant     <= '0;
            done      <= '0;
            err       <= 1'b0;
            tx_start  <= 1'b0;
            de        <= 1'b0;
            tx_active <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_qcnt    <= w_qcnt;
            r_tcnt    <= w_tcnt;
            r_gcnt    <= w_gcnt;
            r_seen    <= w_seen;
            r_errf    <= w_errf;
            grant     <= w_grant;
            done      <= w_done ? w_grant : '0;
            err       <= w_done & w_errf;
            tx_start  <= (w_nstate == c_st_start);
            de        <= w_de;
            tx_active <= w_de | (w_nstate == c_st_hold);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mlvds_tx_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mlvds_tx_sched                                                    |
// | Directed self-checking bench for mlvds_tx_sched (N=2, timeout 100).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mlvds_tx_sched;

    logic       c;
    logic       rst;
    logic       rx_active;
    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] done;
    logic       err;
    logic       tx_start;
    logic       tx_busy;
    logic       de;
    logic       tx_active;

    int total = 0;
    int bad   = 0;
    int de_hi, ta_hi, starts, dones, gr_any;

    mlvds_tx_sched #(
        .N          (2),
        .QUIET      (32),
        .GUARD_PRE  (4),
        .GUARD_POST (4),
        .TURNAROUND (16),
        .TX_TIMEOUT (16'd100)
    ) dut (
        .c         (c),
        .rst       (rst),
        .rx_active (rx_active),
        .req       (req),
        .grant     (grant),
        .done      (done),
        .err       (err),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .de        (de),
        .tx_active (tx_active)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_acc();
        de_hi = 0; ta_hi = 0; starts = 0; dones = 0; gr_any = 0;
    endtask

    // One clock; sample on the falling edge.
    task automatic step();
        @(posedge c);
        @(negedge c);
        de_hi  += int'(de);
        ta_hi  += int'(tx_active);
        starts += int'(tx_start);
        if (done != 2'b00) dones++;
        if (grant != 2'b00) gr_any = 1;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tx_start && n < limit);
    endtask

    // Full transaction: tx_busy high for nbusy clocks starting one clock after tx_start.
    task automatic txn(input string tag, input logic [1:0] g_exp, input int lat_exp, input int nbusy);
        int n;
        wait_start(200, n);
        chk({tag, " latency"}, 32'(n), 32'(lat_exp));
        chk({tag, " grant"}, 32'(grant), 32'(g_exp));
        step();
        tx_busy = 1'b1;
        repeat (nbusy) step();
        tx_busy = 1'b0;
        repeat (3) step();
        chk({tag, " done early"}, 32'(done), 32'd0);
        step();
        chk({tag, " done"}, 32'(done), 32'(g_exp));
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " de in post"}, 32'(de), 32'd1);
        repeat (16) step();
        chk({tag, " ta end hold"}, 32'(tx_active), 32'd1);
        step();
        chk({tag, " ta idle"}, 32'(tx_active), 32'd0);
        chk({tag, " grant idle"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; rx_active = 1'b0; req = 2'b00; tx_busy = 1'b0;
        step(); step();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst tx_start", 32'(tx_start), 32'd0);
        chk("rst de", 32'(de), 32'd0);
        chk("rst tx_active", 32'(tx_active), 32'd0);
        rst = 1'b0;

        // Single requester on an already-quiet bus.
        repeat (40) step();
        clr_acc();
        req = 2'b01;
        step();
        chk("single de arb", 32'(de), 32'd0);
        step();
        chk("single grant pre", 32'(grant), 32'd1);
        chk("single ta pre", 32'(tx_active), 32'd1);
        repeat (3) step();
        chk("single no start", 32'(tx_start), 32'd0);
        step();
        chk("single start at 6", 32'(tx_start), 32'd1);
        step();
        tx_busy = 1'b1;
        repeat (10) step();
        tx_busy = 1'b0;
        repeat (4) step();
        chk("single done", 32'(done), 32'd1);
        chk("single err", 32'(err), 32'd0);
        step();
        chk("single de hold", 32'(de), 32'd0);
        chk("single grant hold", 32'(grant), 32'd0);
        repeat (16) step();
        chk("single ta idle", 32'(tx_active), 32'd0);
        chk("single de cycles", 32'(de_hi), 32'd20);
        chk("single ta cycles", 32'(ta_hi), 32'd36);
        chk("single starts", 32'(starts), 32'd1);
        chk("single dones", 32'(dones), 32'd1);

        // Quiet gating: rx_active pulses keep the bus from ever looking quiet.
        clr_acc();
        repeat (5) begin
            rx_active = 1'b1;
            step();
            rx_active = 1'b0;
            repeat (19) step();
        end
        chk("quiet no grant", 32'(gr_any), 32'd0);
        chk("quiet no de", 32'(de_hi), 32'd0);
        rx_active = 1'b1;
        step();
        rx_active = 1'b0;
        repeat (33) step();
        chk("quiet grant 33", 32'(grant), 32'd0);
        step();
        chk("quiet grant 34", 32'(grant), 32'd1);
        txn("quiet txn", 2'b01, 4, 3);

        // Timeout: tx_busy never rises; rx_active toggles while the bus is owned.
        wait_start(200, n);
        chk("tmo latency", 32'(n), 32'd38);
        rx_active = 1'b1;
        repeat (103) step();
        chk("tmo done early", 32'(done), 32'd0);
        step();
        chk("tmo done", 32'(done), 32'd1);
        chk("tmo err", 32'(err), 32'd1);
        chk("tmo de post", 32'(de), 32'd1);
        rx_active = 1'b0;
        step();
        chk("tmo de drop", 32'(de), 32'd0);
        repeat (16) step();
        chk("tmo ta idle", 32'(tx_active), 32'd0);

        // Abort in PRE: req[0] drops on the second PRE clock.
        clr_acc();
        repeat (34) step();
        chk("abort grant", 32'(grant), 32'd1);
        step();
        req = 2'b00;
        repeat (3) step();
        chk("abort done early", 32'(done), 32'd0);
        step();
        chk("abort done", 32'(done), 32'd1);
        chk("abort err", 32'(err), 32'd1);
        repeat (17) step();
        chk("abort ta idle", 32'(tx_active), 32'd0);
        chk("abort no start", 32'(starts), 32'd0);

        // Reset in the middle of BUSY.
        req = 2'b01;
        clr_acc();
        wait_start(200, n);
        chk("rstb latency", 32'(n), 32'd38);
        step();
        tx_busy = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk("rstb de", 32'(de), 32'd0);
        chk("rstb ta", 32'(tx_active), 32'd0);
        chk("rstb grant", 32'(grant), 32'd0);
        chk("rstb done", 32'(dones), 32'd0);
        rst = 1'b0;
        tx_busy = 1'b0;

        // Contention: pointer restarts at 0, quiet counter restarts from 0.
        req = 2'b11;
        clr_acc();
        txn("cont 1", 2'b01, 38, 5);
        txn("cont 2", 2'b10, 38, 5);
        txn("cont 3", 2'b01, 38, 5);
        txn("cont 4", 2'b10, 38, 5);
        chk("cont dones", 32'(dones), 32'd4);
        chk("cont starts", 32'(starts), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
